// File: rtl/reservation_station.sv
// Out-of-order issue buffer for ALU-class instructions: holds entries until both operands
// arrive via ALU/LSB broadcasts, then issues the lowest-index ready entry to the ALU each cycle.
module reservation_station #(
    parameter int unsigned RS_SIZE = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        clear_in,

    input  logic        issue_valid,
    input  logic [6:0]  issue_opcode,
    input  logic [31:0] issue_pc,
    input  logic [31:0] issue_imm,
    input  logic [31:0] issue_vj,
    input  logic [31:0] issue_vk,
    input  logic        issue_qj_busy,
    input  logic        issue_qk_busy,
    input  logic [4:0]  issue_qj,
    input  logic [4:0]  issue_qk,
    input  logic [4:0]  issue_name,
    output logic        rs_full,

    input  logic        alu_bc_valid,
    input  logic [4:0]  alu_bc_name,
    input  logic [31:0] alu_bc_value,
    input  logic        lsb_bc_valid,
    input  logic [4:0]  lsb_bc_name,
    input  logic [31:0] lsb_bc_value,

    output logic [31:0] alu_pc,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic [31:0] alu_imm,
    output logic [6:0]  alu_opcode,
    output logic [4:0]  alu_calc_name
);
    localparam int unsigned IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] qj_busy_q, qj_busy_d;
    logic [RS_SIZE-1:0] qk_busy_q, qk_busy_d;
    logic [6:0]         opcode_q [RS_SIZE];
    logic [6:0]         opcode_d [RS_SIZE];
    logic [31:0]        pc_q [RS_SIZE];
    logic [31:0]        pc_d [RS_SIZE];
    logic [31:0]        imm_q [RS_SIZE];
    logic [31:0]        imm_d [RS_SIZE];
    logic [31:0]        vj_q [RS_SIZE];
    logic [31:0]        vj_d [RS_SIZE];
    logic [31:0]        vk_q [RS_SIZE];
    logic [31:0]        vk_d [RS_SIZE];
    logic [4:0]         qj_q [RS_SIZE];
    logic [4:0]         qj_d [RS_SIZE];
    logic [4:0]         qk_q [RS_SIZE];
    logic [4:0]         qk_d [RS_SIZE];
    logic [4:0]         name_q [RS_SIZE];
    logic [4:0]         name_d [RS_SIZE];

    logic [RS_SIZE-1:0] ready;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic               free_valid;
    logic [IDX_W-1:0]   free_idx;

    assign ready   = busy_q & ~qj_busy_q & ~qk_busy_q;
    assign rs_full = &busy_q;

    // Descending scan so the last hit is the lowest index.
    always_comb begin
        sel_valid  = 1'b0;
        sel_idx    = '0;
        free_valid = 1'b0;
        free_idx   = '0;
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                free_valid = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        busy_d    = busy_q;
        qj_busy_d = qj_busy_q;
        qk_busy_d = qk_busy_q;
        opcode_d  = opcode_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        vj_d      = vj_q;
        vk_d      = vk_q;
        qj_d      = qj_q;
        qk_d      = qk_q;
        name_d    = name_q;
        if (clear_in) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                if (busy_q[i] && qj_busy_q[i]) begin
                    if (alu_bc_valid && alu_bc_name == qj_q[i]) begin
                        vj_d[i] = alu_bc_value;
                        qj_busy_d[i] = 1'b0;
                    end else if (lsb_bc_valid && lsb_bc_name == qj_q[i]) begin
                        vj_d[i] = lsb_bc_value;
                        qj_busy_d[i] = 1'b0;
                    end
                end
                if (busy_q[i] && qk_busy_q[i]) begin
                    if (alu_bc_valid && alu_bc_name == qk_q[i]) begin
                        vk_d[i] = alu_bc_value;
                        qk_busy_d[i] = 1'b0;
                    end else if (lsb_bc_valid && lsb_bc_name == qk_q[i]) begin
                        vk_d[i] = lsb_bc_value;
                        qk_busy_d[i] = 1'b0;
                    end
                end
            end
            if (sel_valid) busy_d[sel_idx] = 1'b0;
            // Free slot comes from registered state, so it never aliases the selected entry.
            if (issue_valid && !rs_full && free_valid) begin
                busy_d[free_idx]    = 1'b1;
                opcode_d[free_idx]  = issue_opcode;
                pc_d[free_idx]      = issue_pc;
                imm_d[free_idx]     = issue_imm;
                name_d[free_idx]    = issue_name;
                qj_d[free_idx]      = issue_qj;
                qk_d[free_idx]      = issue_qk;
                vj_d[free_idx]      = issue_vj;
                vk_d[free_idx]      = issue_vk;
                qj_busy_d[free_idx] = issue_qj_busy;
                qk_busy_d[free_idx] = issue_qk_busy;
                if (issue_qj_busy) begin
                    if (alu_bc_valid && alu_bc_name == issue_qj) begin
                        vj_d[free_idx] = alu_bc_value;
                        qj_busy_d[free_idx] = 1'b0;
                    end else if (lsb_bc_valid && lsb_bc_name == issue_qj) begin
                        vj_d[free_idx] = lsb_bc_value;
                        qj_busy_d[free_idx] = 1'b0;
                    end
                end
                if (issue_qk_busy) begin
                    if (alu_bc_valid && alu_bc_name == issue_qk) begin
                        vk_d[free_idx] = alu_bc_value;
                        qk_busy_d[free_idx] = 1'b0;
                    end else if (lsb_bc_valid && lsb_bc_name == issue_qk) begin
                        vk_d[free_idx] = lsb_bc_value;
                        qk_busy_d[free_idx] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q    <= '0;
            qj_busy_q <= '0;
            qk_busy_q <= '0;
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                opcode_q[i] <= '0;
                pc_q[i]     <= '0;
                imm_q[i]    <= '0;
                vj_q[i]     <= '0;
                vk_q[i]     <= '0;
                qj_q[i]     <= '0;
                qk_q[i]     <= '0;
                name_q[i]   <= '0;
            end
        end else begin
            busy_q    <= busy_d;
            qj_busy_q <= qj_busy_d;
            qk_busy_q <= qk_busy_d;
            opcode_q  <= opcode_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            vj_q      <= vj_d;
            vk_q      <= vk_d;
            qj_q      <= qj_d;
            qk_q      <= qk_d;
            name_q    <= name_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            alu_pc        <= '0;
            alu_rs1       <= '0;
            alu_rs2       <= '0;
            alu_imm       <= '0;
            alu_opcode    <= '0;
            alu_calc_name <= '0;
        end else if (clear_in || !sel_valid) begin
            alu_opcode <= '0;
        end else begin
            alu_pc        <= pc_q[sel_idx];
            alu_rs1       <= vj_q[sel_idx];
            alu_rs2       <= vk_q[sel_idx];
            alu_imm       <= imm_q[sel_idx];
            alu_opcode    <= opcode_q[sel_idx];
            alu_calc_name <= name_q[sel_idx];
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: latency, wakeup, bypass, ordering, full, flush, reset.
module tb_reservation_station;
    localparam logic [6:0] OP_ADD  = 7'd1;
    localparam logic [6:0] OP_ADDI = 7'd10;
    localparam logic [6:0] OP_BEQ  = 7'd20;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        clear_in;
    logic        issue_valid;
    logic [6:0]  issue_opcode;
    logic [31:0] issue_pc, issue_imm, issue_vj, issue_vk;
    logic        issue_qj_busy, issue_qk_busy;
    logic [4:0]  issue_qj, issue_qk, issue_name;
    logic        rs_full;
    logic        alu_bc_valid, lsb_bc_valid;
    logic [4:0]  alu_bc_name, lsb_bc_name;
    logic [31:0] alu_bc_value, lsb_bc_value;
    logic [31:0] alu_pc, alu_rs1, alu_rs2, alu_imm;
    logic [6:0]  alu_opcode;
    logic [4:0]  alu_calc_name;

    int n_checks = 0;
    int n_pass   = 0;

    reservation_station #(.RS_SIZE(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .clear_in(clear_in),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_pc(issue_pc),
        .issue_imm(issue_imm), .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
        .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_name(issue_name),
        .rs_full(rs_full),
        .alu_bc_valid(alu_bc_valid), .alu_bc_name(alu_bc_name), .alu_bc_value(alu_bc_value),
        .lsb_bc_valid(lsb_bc_valid), .lsb_bc_name(lsb_bc_name), .lsb_bc_value(lsb_bc_value),
        .alu_pc(alu_pc), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm),
        .alu_opcode(alu_opcode), .alu_calc_name(alu_calc_name)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Advance one clock; inputs and samples both sit 1 time unit after the edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        issue_valid   = 1'b0;
        clear_in      = 1'b0;
        alu_bc_valid  = 1'b0;
        lsb_bc_valid  = 1'b0;
    endtask

    task automatic issue(input logic [6:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic qjb, input logic [4:0] qj, input logic [4:0] name,
                         input logic [31:0] imm);
        issue_valid   = 1'b1;
        issue_opcode  = op;
        issue_pc      = 32'h1000 + {27'd0, name};
        issue_imm     = imm;
        issue_vj      = vj;
        issue_vk      = vk;
        issue_qj_busy = qjb;
        issue_qj      = qj;
        issue_qk_busy = 1'b0;
        issue_qk      = 5'd0;
        issue_name    = name;
    endtask

    initial begin
        rst_in = 1'b1;
        idle();
        issue(OP_ADD, 0, 0, 0, 0, 0, 0);
        issue_valid = 1'b0;
        alu_bc_name = 0; alu_bc_value = 0; lsb_bc_name = 0; lsb_bc_value = 0;
        step(); step();
        check("reset_opcode", {25'd0, alu_opcode}, 0);
        check("reset_rs1", alu_rs1, 0);
        check("reset_full", {31'd0, rs_full}, 0);
        rst_in = 1'b0;

        // ADD with both operands ready: latency 2, single cycle on the bus.
        issue(OP_ADD, 5, 7, 0, 0, 3, 0);
        step(); idle();
        check("add_n1_idle", {25'd0, alu_opcode}, 0);
        step();
        check("add_opcode", {25'd0, alu_opcode}, {25'd0, OP_ADD});
        check("add_rs1", alu_rs1, 5);
        check("add_rs2", alu_rs2, 7);
        check("add_name", {27'd0, alu_calc_name}, 3);
        check("add_pc", alu_pc, 32'h1003);
        step();
        check("add_n3_idle", {25'd0, alu_opcode}, 0);

        // BEQ waiting on ALU broadcast of name 4.
        issue(OP_BEQ, 0, 1, 1, 4, 5, 0);
        step(); idle();
        step();
        check("beq_wait", {25'd0, alu_opcode}, 0);
        alu_bc_valid = 1'b1; alu_bc_name = 4; alu_bc_value = 32'h10;
        step(); idle();
        check("beq_m1_idle", {25'd0, alu_opcode}, 0);
        step();
        check("beq_opcode", {25'd0, alu_opcode}, {25'd0, OP_BEQ});
        check("beq_rs1", alu_rs1, 32'h10);
        check("beq_rs2", alu_rs2, 1);

        // ADDI bypassed by an LSB broadcast in its issue cycle.
        issue(OP_ADDI, 0, 0, 1, 6, 8, 3);
        lsb_bc_valid = 1'b1; lsb_bc_name = 6; lsb_bc_value = 9;
        step(); idle();
        check("byp_n1_idle", {25'd0, alu_opcode}, 0);
        step();
        check("byp_opcode", {25'd0, alu_opcode}, {25'd0, OP_ADDI});
        check("byp_rs1", alu_rs1, 9);
        check("byp_imm", alu_imm, 3);

        // Entries 0 and 2 wait on name 20, entry 1 on name 21.
        step();
        issue(OP_ADD, 0, 100, 1, 20, 10, 0); step();
        issue(OP_ADD, 0, 101, 1, 21, 11, 0); step();
        issue(OP_ADD, 0, 102, 1, 20, 12, 0); step(); idle();
        alu_bc_valid = 1'b1; alu_bc_name = 20; alu_bc_value = 77;
        step(); idle();
        check("ord_m1_idle", {25'd0, alu_opcode}, 0);
        step();
        check("ord_first", {27'd0, alu_calc_name}, 10);
        check("ord_first_rs1", alu_rs1, 77);
        step();
        check("ord_second", {27'd0, alu_calc_name}, 12);
        check("ord_second_rs2", alu_rs2, 102);
        step();
        check("ord_entry1_waits", {25'd0, alu_opcode}, 0);
        lsb_bc_valid = 1'b1; lsb_bc_name = 21; lsb_bc_value = 55;
        step(); idle(); step();
        check("ord_entry1", {27'd0, alu_calc_name}, 11);
        check("ord_entry1_rs1", alu_rs1, 55);
        step();

        // Fill all 16 entries waiting on name 1.
        for (int k = 0; k < 16; k++) begin
            issue(OP_ADD, 0, k, 1, 1, 5'(k), 0);
            step();
        end
        idle();
        check("full_set", {31'd0, rs_full}, 1);
        issue(OP_ADDI, 1, 1, 0, 0, 31, 0);
        step(); idle();
        check("full_still", {31'd0, rs_full}, 1);
        alu_bc_valid = 1'b1; alu_bc_name = 1; alu_bc_value = 2;
        step(); idle();
        check("full_m1", {31'd0, rs_full}, 1);
        check("full_m1_idle", {25'd0, alu_opcode}, 0);
        step();
        check("full_drop", {31'd0, rs_full}, 0);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("drain_name%0d", k), {27'd0, alu_calc_name}, k);
            check($sformatf("drain_rs1_%0d", k), alu_rs1, 2);
            step();
        end
        check("drained_idle", {25'd0, alu_opcode}, 0);

        // Five pending entries, then flush with a colliding issue and broadcast.
        for (int k = 0; k < 5; k++) begin
            issue(OP_ADD, 0, 0, 1, 7, 5'(k + 16), 0);
            step();
        end
        issue(OP_ADD, 1, 1, 0, 0, 25, 0);
        clear_in = 1'b1;
        alu_bc_valid = 1'b1; alu_bc_name = 7; alu_bc_value = 3;
        step(); idle();
        check("clr_full", {31'd0, rs_full}, 0);
        check("clr_opcode", {25'd0, alu_opcode}, 0);
        alu_bc_valid = 1'b1; alu_bc_name = 7; alu_bc_value = 3;
        step(); idle();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("clr_quiet%0d", k), {25'd0, alu_opcode}, 0);
            step();
        end

        // Asynchronous reset mid-run with a dispatch on the bus and one entry pending.
        issue(OP_ADD, 0, 0, 1, 9, 2, 0); step();
        issue(OP_ADD, 11, 12, 0, 0, 4, 0); step(); idle();
        step();
        check("pre_rst_opcode", {25'd0, alu_opcode}, {25'd0, OP_ADD});
        #2 rst_in = 1'b1;
        #1;
        check("rst_opcode", {25'd0, alu_opcode}, 0);
        check("rst_rs1", alu_rs1, 0);
        check("rst_full", {31'd0, rs_full}, 0);
        step();
        rst_in = 1'b0;
        alu_bc_valid = 1'b1; alu_bc_name = 9; alu_bc_value = 1;
        step(); idle();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_quiet%0d", k), {25'd0, alu_opcode}, 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
